// File: rtl/cpu_pkg.sv
// Shared definitions for the processor front end.
//   - opcode constants seen by the decoder
//   - instruction field bit positions
//   - fetch state encoding
//   - helper that turns an RD word offset into a signed 32-bit byte offset
package cpu_pkg;

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_J     = 8'd4;
  localparam logic [7:0] OP_BEQ   = 8'd5;
  localparam logic [7:0] OP_MOV   = 8'd6;
  localparam logic [7:0] OP_LOADI = 8'd7;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int RD_MSB     = 23;
  localparam int RD_LSB     = 16;
  localparam int RT_MSB     = 15;
  localparam int RT_LSB     = 8;
  localparam int RS_MSB     = 7;
  localparam int RS_LSB     = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;

  // Sign-extend an 8-bit word offset and scale it to bytes (x4).
  function automatic logic [31:0] word_offset_to_bytes(input logic [7:0] rd);
    return {{22{rd[7]}}, rd, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational next-PC candidates.
//   pc     : current program counter
//   rd     : signed word offset from the instruction's RD field
//   pc4    : pc + 4 (sequential successor, 32-bit wrap)
//   target : pc4 + sign_extend(rd) * 4 (32-bit wrap)
module branch_target_adder
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [7:0]  rd,
  output logic [31:0] pc4,
  output logic [31:0] target
);

  logic [31:0] pc4_s;

  // Sequential successor and relative branch/jump destination.
  always_comb begin
    pc4_s  = pc + 32'd4;
    pc4    = pc4_s;
    target = pc4_s + word_offset_to_bytes(rd);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-side front end: owns the PC, fetches a 32-bit word over a
// read/busywait handshake, splits it into decoder fields and picks the next
// PC from the decoder's jump/branch signals and the ALU zero flag.
// Ports:
//   CLK, RESET (async, active-low)
//   IREAD / IADDRESS / IREADDATA / IBUSYWAIT : instruction memory handshake
//   OPCODE / RD / RT / RS / INSTR_VALID      : latched instruction fields
//   BEQSIGNAL / JSIGNAL / ZERO               : branch resolution inputs
//   DBUSYWAIT                                : data memory busy, holds EXEC
//   PC                                       : current program counter
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'd0,
  parameter int          IADDR_WIDTH   = 8,
  parameter int          DECODE_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  output logic                   IREAD,
  output logic [IADDR_WIDTH-1:0] IADDRESS,
  input  logic [31:0]            IREADDATA,
  input  logic                   IBUSYWAIT,
  output logic [7:0]             OPCODE,
  output logic [7:0]             RD,
  output logic [7:0]             RT,
  output logic [7:0]             RS,
  output logic                   INSTR_VALID,
  input  logic                   BEQSIGNAL,
  input  logic                   JSIGNAL,
  input  logic                   ZERO,
  input  logic                   DBUSYWAIT,
  output logic [31:0]            PC
);

  localparam logic [3:0] DECODE_LAST = 4'(DECODE_CYCLES - 1);

  logic [1:0]  state_r;
  logic [3:0]  decode_cnt_r;
  logic [31:0] pc_r;
  logic        iread_r;
  logic        instr_valid_r;
  logic [7:0]  opcode_r;
  logic [7:0]  rd_r;
  logic [7:0]  rt_r;
  logic [7:0]  rs_r;

  logic [31:0] pc4_s;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;

  branch_target_adder u_bta (
    .pc     (pc_r),
    .rd     (rd_r),
    .pc4    (pc4_s),
    .target (target_s)
  );

  // Next-PC selection; a jump wins over a taken branch.
  always_comb begin
    next_pc_s = pc4_s;
    if (JSIGNAL) begin
      next_pc_s = target_s;
    end else if (BEQSIGNAL && ZERO) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // Fetch/decode/execute sequencer with PC and instruction field registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= ST_IDLE;
      decode_cnt_r  <= 4'd0;
      pc_r          <= RESET_PC;
      iread_r       <= 1'b0;
      instr_valid_r <= 1'b0;
      opcode_r      <= 8'd0;
      rd_r          <= 8'd0;
      rt_r          <= 8'd0;
      rs_r          <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_FETCH;
          iread_r <= 1'b1;
        end
        ST_FETCH: begin
          // Request stays asserted with a stable address until memory answers.
          if (!IBUSYWAIT) begin
            opcode_r      <= IREADDATA[OPCODE_MSB:OPCODE_LSB];
            rd_r          <= IREADDATA[RD_MSB:RD_LSB];
            rt_r          <= IREADDATA[RT_MSB:RT_LSB];
            rs_r          <= IREADDATA[RS_MSB:RS_LSB];
            instr_valid_r <= 1'b1;
            iread_r       <= 1'b0;
            decode_cnt_r  <= DECODE_LAST;
            state_r       <= ST_DECODE;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (decode_cnt_r == 4'd0) begin
            state_r <= ST_EXEC;
          end else begin
            decode_cnt_r <= decode_cnt_r - 4'd1;
          end
        end
        ST_EXEC: begin
          // A busy data memory freezes the whole instruction in place.
          if (!DBUSYWAIT) begin
            pc_r          <= next_pc_s;
            instr_valid_r <= 1'b0;
            iread_r       <= 1'b1;
            state_r       <= ST_FETCH;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          iread_r       <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign IREAD       = iread_r;
  assign IADDRESS    = pc_r[IADDR_WIDTH+1:2];
  assign OPCODE      = opcode_r;
  assign RD          = rd_r;
  assign RT          = rt_r;
  assign RS          = rs_r;
  assign INSTR_VALID = instr_valid_r;
  assign PC          = pc_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver pushes expected fetches and
// fields into queues, a negedge monitor pops and compares them.
module tb_pc_fetch_unit;

  localparam int DC = 1;

  logic        CLK;
  logic        RESET;
  logic        IREAD;
  logic [7:0]  IADDRESS;
  logic [31:0] IREADDATA;
  logic        IBUSYWAIT;
  logic [7:0]  OPCODE, RD, RT, RS;
  logic        INSTR_VALID;
  logic        BEQSIGNAL, JSIGNAL, ZERO, DBUSYWAIT;
  logic [31:0] PC;

  pc_fetch_unit #(.RESET_PC(32'd0), .IADDR_WIDTH(8), .DECODE_CYCLES(DC)) dut (
    .CLK(CLK), .RESET(RESET), .IREAD(IREAD), .IADDRESS(IADDRESS),
    .IREADDATA(IREADDATA), .IBUSYWAIT(IBUSYWAIT), .OPCODE(OPCODE), .RD(RD),
    .RT(RT), .RS(RS), .INSTR_VALID(INSTR_VALID), .BEQSIGNAL(BEQSIGNAL),
    .JSIGNAL(JSIGNAL), .ZERO(ZERO), .DBUSYWAIT(DBUSYWAIT), .PC(PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    int          gap;   // expected cycles since previous fetch start, -1 = skip
  } fetch_exp_t;

  fetch_exp_t  fetch_q[$];
  logic [31:0] field_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;
  logic iread_d = 1'b0;
  logic valid_d = 1'b0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference next PC from the architectural rule, using signed integer math.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [7:0] rd,
                                           input bit j, input bit b, input bit z);
    int off;
    off = (rd >= 8'd128) ? (int'(rd) - 256) : int'(rd);
    if (j || (b && z)) return pc + 32'd4 + 32'(off * 4);
    else               return pc + 32'd4;
  endfunction

  // Monitor: every new fetch and every newly valid instruction is scored.
  always @(negedge CLK) begin
    fetch_exp_t fe;
    logic [31:0] w;
    cyc++;
    if (IREAD && !iread_d) begin
      if (fetch_q.size() == 0) begin
        check("unexpected_fetch", 32'd1, 32'd0);
      end else begin
        fe = fetch_q.pop_front();
        check("fetch_pc", PC, fe.pc);
        check("fetch_iaddress", 32'(IADDRESS), 32'(fe.pc[9:2]));
        if (fe.gap >= 0) check("fetch_gap", 32'(cyc - last_rise), 32'(fe.gap));
      end
      last_rise = cyc;
    end
    if (INSTR_VALID && !valid_d) begin
      if (field_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        w = field_q.pop_front();
        check("field_opcode", 32'(OPCODE), 32'(w[31:24]));
        check("field_rd", 32'(RD), 32'(w[23:16]));
        check("field_rt", 32'(RT), 32'(w[15:8]));
        check("field_rs", 32'(RS), 32'(w[7:0]));
      end
    end
    iread_d = IREAD;
    valid_d = INSTR_VALID;
  end

  // One instruction: wait for fetch, optional memory stalls, then PC update.
  task automatic run_instr(input logic [31:0] word, input bit j, input bit b, input bit z,
                           input int ibw, input int dbw,
                           input bit has_exp, input logic [31:0] exp_next);
    int n;
    logic [31:0] nxt;
    n = 0;
    while (!IREAD && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IREAD) check("fetch_timeout", 32'd0, 32'd1);
    for (int i = 0; i < ibw; i++) begin
      IREADDATA = $urandom;
      @(negedge CLK);
      check("stall_iread", 32'(IREAD), 32'd1);
      check("stall_valid", 32'(INSTR_VALID), 32'd0);
      check("stall_iaddress", 32'(IADDRESS), 32'(model_pc[9:2]));
    end
    JSIGNAL   = j;
    BEQSIGNAL = b;
    ZERO      = z;
    DBUSYWAIT = (dbw > 0);
    IREADDATA = word;
    IBUSYWAIT = 1'b0;
    field_q.push_back(word);
    @(negedge CLK);
    IBUSYWAIT = 1'b1;
    IREADDATA = $urandom;
    repeat (DC) @(negedge CLK);
    for (int i = 0; i < dbw; i++) begin
      @(negedge CLK);
      check("dstall_pc", PC, model_pc);
      check("dstall_opcode", 32'(OPCODE), 32'(word[31:24]));
      check("dstall_valid", 32'(INSTR_VALID), 32'd1);
    end
    nxt = ref_next(model_pc, word[23:16], j, b, z);
    fetch_q.push_back('{pc: nxt, gap: ibw + DC + dbw + 2});
    model_pc  = nxt;
    DBUSYWAIT = 1'b0;
    @(negedge CLK);
    if (has_exp) check("directed_next_pc", PC, exp_next);
    JSIGNAL = 1'b0; BEQSIGNAL = 1'b0; ZERO = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; IBUSYWAIT = 1'b1; DBUSYWAIT = 1'b0; IREADDATA = 32'd0;
    BEQSIGNAL = 1'b0; JSIGNAL = 1'b0; ZERO = 1'b0;
    model_pc = 32'd0;
    repeat (3) @(negedge CLK);
    check("reset_pc", PC, 32'd0);
    check("reset_iread", 32'(IREAD), 32'd0);
    check("reset_valid", 32'(INSTR_VALID), 32'd0);
    check("reset_opcode", 32'(OPCODE), 32'd0);
    fetch_q.push_back('{pc: 32'd0, gap: -1});
    RESET = 1'b1;
    @(negedge CLK);
    check("first_iread", 32'(IREAD), 32'd1);
    check("first_iaddress", 32'(IADDRESS), 32'd0);

    // Directed sequence with hand-derived next PCs.
    run_instr(32'h07040005, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h4);
    run_instr(32'h00010203, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h8);
    run_instr(32'h05FE0102, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 32'h4);
    run_instr(32'h00000000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h8);
    run_instr(32'h05FE0102, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 32'hC);
    run_instr(32'h06000000, 1'b0, 1'b0, 1'b0, 5, 0, 1'b1, 32'h10);
    run_instr(32'h04030000, 1'b1, 1'b0, 1'b0, 0, 4, 1'b1, 32'h20);
    run_instr(32'h04010000, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 32'h28);

    // Reset while a fetch is stalled: outputs clear without a clock edge.
    IBUSYWAIT = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("midreset_iread", 32'(IREAD), 32'd0);
    check("midreset_pc", PC, 32'd0);
    check("midreset_valid", 32'(INSTR_VALID), 32'd0);
    @(negedge CLK);
    model_pc = 32'd0;
    fetch_q.push_back('{pc: 32'd0, gap: -1});
    RESET = 1'b1;

    // Negative-offset wrap below zero, then forward wrap through 0xFFFFFFFC.
    run_instr(32'h04800000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'hFFFFFE04);
    run_instr(32'h047F0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'h00000004);

    // Randomized instructions, decoder outputs and memory stalls.
    for (int k = 0; k < 40; k++) begin
      run_instr($urandom, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, 32'd0);
    end

    repeat (3) @(negedge CLK);
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("field_q_drained", 32'(field_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-side front end of the single-cycle processor. It owns the program counter and fetches 32-bit instruction words from instruction memory over a read/busywait handshake. It splits each word into OPCODE and operand fields for the opcode decoder. It then consumes the decoder's BEQSIGNAL/JSIGNAL, plus the ALU ZERO flag, to choose the next PC.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
IADDR_WIDTH, 8, instruction-memory word-address width (IADDRESS = PC[IADDR_WIDTH+1:2])
DECODE_CYCLES, 1, cycles spent in DECODE for decoder and datapath settling (legal range 1..15)

Ports:
CLK  in  1  system clock, rising-edge
RESET  in  1  asynchronous, active-low reset
IREAD  out  1  instruction read request
IADDRESS  out  IADDR_WIDTH  instruction word address
IREADDATA  in  32  instruction word from memory
IBUSYWAIT  in  1  instruction memory busy; data valid when low
OPCODE  out  8  instruction bits [31:24], to decoder
RD  out  8  bits [23:16]: destination register, or branch/jump word offset
RT  out  8  bits [15:8]: source register 1
RS  out  8  bits [7:0]: source register 2 or immediate
INSTR_VALID  out  1  latched instruction fields are valid
BEQSIGNAL  in  1  from decoder: current instruction is beq
JSIGNAL  in  1  from decoder: current instruction is j
ZERO  in  1  ALU zero flag
DBUSYWAIT  in  1  data memory busy; freezes PC update
PC  out  32  current program counter

Behaviour:
- Reset (RESET=0, takes effect immediately, independent of CLK):
  - PC=RESET_PC, state=IDLE.
  - IREAD=0, INSTR_VALID=0.
  - OPCODE/RD/RT/RS=0.
  - Any outstanding fetch is abandoned; no data is latched.
- States: IDLE, FETCH, DECODE, EXEC.
  - IDLE: first rising edge after reset release -> FETCH.
  - FETCH:
    - IREAD=1, IADDRESS=PC word address, both held stable.
    - On a rising edge with IBUSYWAIT=0: latch IREADDATA into the OPCODE/RD/RT/RS registers, set INSTR_VALID=1, go to DECODE with counter=DECODE_CYCLES-1.
    - IREAD drops to 0 in the same edge.
  - DECODE:
    - Fields are held stable. The decoder and datapath settle.
    - Counter decrements each cycle; at 0 -> EXEC.
  - EXEC: on a rising edge with DBUSYWAIT=0:
    - PC <= next_pc, INSTR_VALID <= 0, go to FETCH.
    - With DBUSYWAIT=1, stay in EXEC with PC and fields frozen.
- next_pc:
  - pc4 = PC+4.
  - target = pc4 + (sign-extended RD << 2).
  - JSIGNAL=1 -> target.
  - Else BEQSIGNAL=1 and ZERO=1 -> target.
  - Else pc4.
  - JSIGNAL has priority if both decoder signals are high.
- Arithmetic is 32-bit modulo: PC wraps 0xFFFFFFFC+4 -> 0; a negative offset below 0 wraps.
- RD offset range is -128..+127 words.
- Unknown opcodes: decoder signals are expected to be 0, giving PC+4. The block itself never faults.
- Throughput: with zero-wait memories, one instruction per 2+DECODE_CYCLES cycles (3 by default).
- IBUSYWAIT is ignored outside FETCH. DBUSYWAIT is ignored outside EXEC.
- BEQSIGNAL/JSIGNAL/ZERO are sampled only at the EXEC update edge.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_J=4, OP_BEQ=5, OP_MOV=6, OP_LOADI=7.
  - instruction field bit positions.
  - fetch state encoding.
- One sub-module: branch_target_adder, a combinational block that computes pc4 and target from PC and RD.

Test Plan:
1. Reset and first fetch:
   - Hold RESET=0: PC=0, IREAD=0, INSTR_VALID=0.
   - Release RESET: after one edge IREAD=1, IADDRESS=0.
2. Zero-wait sequential fetch:
   - Memory word 0x07040005 at address 0: OPCODE=0x07, RD=0x04, RT=0x00, RS=0x05, INSTR_VALID=1.
   - PC goes 0 -> 4 -> 8, with each update 3 cycles apart.
3. beq:
   - Taken: at PC=8 with RD=0xFE, BEQSIGNAL=1, ZERO=1 -> PC=4.
   - Not taken: same instruction with ZERO=0 -> PC=12.
4. Jump:
   - j at PC=0x10 with RD=0x03 -> PC=0x20.
   - JSIGNAL=1 and BEQSIGNAL=1 with ZERO=0 -> jump taken.
   - Wrap: RD=0x80 at PC=0 -> PC=0xFFFFFE04.
5. Stalls:
   - IBUSYWAIT=1 for 5 cycles: IREAD and IADDRESS held, no latch.
   - DBUSYWAIT=1 in EXEC for 4 cycles: PC and fields frozen; update happens on the first edge with DBUSYWAIT=0.
6. Mid-operation reset:
   - Drop RESET during a FETCH wait: IREAD=0 and PC=RESET_PC immediately, with no clock edge needed.
   - After release, fetch restarts from RESET_PC.
